libhdl_sync_bus_stable: RTL and testbench

//   Multi-bit synchroniser with a stability qualifier. i_bus is asynchronous to i_clk.
//   It passes through an NFF-stage ASYNC_REG chain; the synchronised word s = sync_ff[NFF-1].
//   o_bus takes a new value only after s has held one value for STABLE consecutive cycles.

---
 rtl/libhdl_sync_bus_stable_if.sv | 21 ++
 rtl/libhdl_sync_bus_stable.sv | 136 +++++++++++++
 tb/tb_libhdl_sync_bus_stable.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/libhdl_sync_bus_stable_if.sv
// Bus bundle for libhdl_sync_bus_stable: asynchronous input word plus qualified outputs.
interface libhdl_sync_bus_stable_if #(
  parameter int W = 32
);
  logic [W-1:0] i_bus;
  logic [W-1:0] o_bus;
  logic         o_upd;
  logic         o_busy;
  logic [W-1:0] o_rise;
  logic [W-1:0] o_fall;

  modport master (
    output i_bus,
    input  o_bus, o_upd, o_busy, o_rise, o_fall
  );

  modport slave (
    input  i_bus,
    output o_bus, o_upd, o_busy, o_rise, o_fall
  );
endinterface

// File: rtl/libhdl_sync_bus_stable.sv
// Multi-bit synchroniser that only forwards a word after it has held steady for STABLE cycles.
// Optional per-bit rise/fall pulses on acceptance: define LIBHDL_SYNC_BUS_STABLE_EDGE_EN.
module libhdl_sync_bus_stable #(
  parameter int           W        = 32,
  parameter int           NFF      = 2,
  parameter int           STABLE   = 4,
  parameter logic [W-1:0] INIT_VAL = '0
) (
  input logic                      i_clk,
  input logic                      i_rst,
  libhdl_sync_bus_stable_if.slave  bus
);

  localparam int             CW       = $clog2(STABLE + 1);
  localparam logic [CW-1:0]  STABLE_C = CW'(STABLE);
  localparam logic [CW-1:0]  ONE_C    = CW'(1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SETTLE = 1'b1;

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync_q [NFF];

  logic [W-1:0]  s;
  logic [W-1:0]  cand_q, cand_d;
  logic [W-1:0]  obus_q, obus_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic [0:0]    state_q, state_d;
  logic          upd_q,  upd_d;
  logic          busy_q;
  logic          accept;

  assign s = sync_q[NFF-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < NFF; k++) sync_q[k] <= INIT_VAL;
    end else begin
      sync_q[0] <= bus.i_bus;
      for (int unsigned k = 1; k < NFF; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    obus_d  = obus_q;
    cnt_d   = cnt_q;
    upd_d   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s != obus_q) begin
          state_d = SETTLE;
          cand_d  = s;
          cnt_d   = ONE_C;
        end
      end
      default: begin
        if (s == cand_q) begin
          if (cnt_q == STABLE_C) begin
            accept  = 1'b1;
            obus_d  = cand_q;
            upd_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end else if (s == obus_q) begin
          // Word fell back to the accepted value: drop the candidate silently.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cand_d = s;
          cnt_d  = ONE_C;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cand_q  <= INIT_VAL;
      obus_q  <= INIT_VAL;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      obus_q  <= obus_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      busy_q  <= (state_d == SETTLE);
    end
  end

  assign bus.o_bus  = obus_q;
  assign bus.o_upd  = upd_q;
  assign bus.o_busy = busy_q;

`ifdef LIBHDL_SYNC_BUS_STABLE_EDGE_EN
  logic [W-1:0] rise_q, rise_d;
  logic [W-1:0] fall_q, fall_d;

  // Edges compare the outgoing o_bus against the word being accepted.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    if (accept) begin
      rise_d = ~obus_q & cand_q;
      fall_d = obus_q & ~cand_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.o_rise = rise_q;
  assign bus.o_fall = fall_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign bus.o_rise    = '0;
  assign bus.o_fall    = '0;
`endif

endmodule

// File: tb/tb_libhdl_sync_bus_stable.sv
// Directed and random checks of libhdl_sync_bus_stable against a run-length reference model.
module tb_libhdl_sync_bus_stable;

  localparam int         W    = 8;
  localparam int         NFF  = 2;
  localparam logic [7:0] INIT = 8'h5A;

  logic clk;
  logic rst;

  libhdl_sync_bus_stable_if #(.W(W)) bus_a ();
  libhdl_sync_bus_stable_if #(.W(W)) bus_b ();

  libhdl_sync_bus_stable #(.W(W), .NFF(NFF), .STABLE(4), .INIT_VAL(INIT)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a.slave)
  );

  libhdl_sync_bus_stable #(.W(W), .NFF(NFF), .STABLE(1), .INIT_VAL(INIT)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the FSM sees the input sampled NFF edges earlier; a new
  // word is accepted once it has been seen on STABLE+1 consecutive edges.
  int         stab [2] = '{4, 1};
  logic [7:0] hist [2][NFF];
  logic [7:0] m_obus [2];
  logic [7:0] m_prev [2];
  int         m_run  [2];
  logic       e_upd  [2];
  logic       e_busy [2];
  logic [7:0] e_rise [2];
  logic [7:0] e_fall [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int i, input logic [7:0] v, input logic r);
    logic [7:0] s;
    s = hist[i][NFF-1];
    for (int k = NFF - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
    hist[i][0] = v;
    e_upd[i]  = 1'b0;
    e_rise[i] = 8'h00;
    e_fall[i] = 8'h00;
    if (r) begin
      for (int k = 0; k < NFF; k++) hist[i][k] = INIT;
      m_obus[i] = INIT;
      m_prev[i] = INIT;
      m_run[i]  = 0;
      e_busy[i] = 1'b0;
      return;
    end
    m_run[i]  = (s == m_prev[i]) ? m_run[i] + 1 : 1;
    m_prev[i] = s;
    if (s == m_obus[i]) begin
      e_busy[i] = 1'b0;
    end else if (m_run[i] >= stab[i] + 1) begin
`ifdef LIBHDL_SYNC_BUS_STABLE_EDGE_EN
      e_rise[i] = ~m_obus[i] & s;
      e_fall[i] = m_obus[i] & ~s;
`endif
      m_obus[i] = s;
      e_upd[i]  = 1'b1;
      e_busy[i] = 1'b0;
    end else begin
      e_busy[i] = 1'b1;
    end
  endtask

  task automatic check_models();
    chk("A.o_bus",  bus_a.o_bus,        m_obus[0]);
    chk("A.o_upd",  {7'd0, bus_a.o_upd},  {7'd0, e_upd[0]});
    chk("A.o_busy", {7'd0, bus_a.o_busy}, {7'd0, e_busy[0]});
    chk("A.o_rise", bus_a.o_rise,       e_rise[0]);
    chk("A.o_fall", bus_a.o_fall,       e_fall[0]);
    chk("B.o_bus",  bus_b.o_bus,        m_obus[1]);
    chk("B.o_upd",  {7'd0, bus_b.o_upd},  {7'd0, e_upd[1]});
    chk("B.o_busy", {7'd0, bus_b.o_busy}, {7'd0, e_busy[1]});
    chk("B.o_rise", bus_b.o_rise,       e_rise[1]);
    chk("B.o_fall", bus_b.o_fall,       e_fall[1]);
  endtask

  task automatic step(input logic [7:0] v);
    bus_a.i_bus = v;
    bus_b.i_bus = v;
    @(posedge clk);
    model_edge(0, v, rst);
    model_edge(1, v, rst);
    #1;
    check_models();
  endtask

  initial begin
    int         upd_cnt;
    logic [7:0] v;
    logic [7:0] pool [5];
    pool = '{8'h00, 8'hFF, 8'h5A, 8'h3C, 8'h00};

    rst = 1'b1;
    bus_a.i_bus = 8'hFF;
    bus_b.i_bus = 8'hFF;

    // T1: reset holds INIT regardless of input
    for (int e = 0; e < 3; e++) begin
      step(8'hFF);
      chk("T1.o_bus",  bus_a.o_bus, 8'h5A);
      chk("T1.o_upd",  {7'd0, bus_a.o_upd},  8'h00);
      chk("T1.o_busy", {7'd0, bus_a.o_busy}, 8'h00);
    end
    rst = 1'b0;

    // T2: latency from a clean change
    repeat (10) step(8'h00);
    chk("T2.pre", bus_a.o_bus, 8'h00);
    for (int e = 1; e <= 9; e++) begin
      step(8'h3C);
      chk($sformatf("T2.busy@%0d", e), {7'd0, bus_a.o_busy}, {7'd0, (e >= 3 && e < 7)});
      chk($sformatf("T2.upd@%0d", e),  {7'd0, bus_a.o_upd},  {7'd0, (e == 7)});
      chk($sformatf("T2.bus@%0d", e),  bus_a.o_bus, (e >= 7) ? 8'h3C : 8'h00);
    end

    // T3: short glitch rejected
    repeat (10) step(8'h00);
    chk("T3.pre", bus_a.o_bus, 8'h00);
    upd_cnt = 0;
    repeat (2) step(8'h3C);
    for (int e = 0; e < 8; e++) begin
      step(8'h00);
      if (bus_a.o_upd) upd_cnt++;
      chk("T3.o_bus", bus_a.o_bus, 8'h00);
    end
    chk("T3.no_upd", upd_cnt[7:0], 8'd0);

    // T4: candidate restart skips the intermediate word
    upd_cnt = 0;
    repeat (2) step(8'h11);
    for (int e = 0; e < 12; e++) begin
      step(8'h22);
      if (bus_a.o_upd) upd_cnt++;
      chk("T4.not11", {7'd0, bus_a.o_bus == 8'h11}, 8'h00);
    end
    chk("T4.one_upd", upd_cnt[7:0], 8'd1);
    chk("T4.o_bus", bus_a.o_bus, 8'h22);

    // T5: STABLE=1 instance accepts at edge NFF+2
    repeat (10) step(8'h00);
    for (int e = 1; e <= 6; e++) begin
      step(8'hA5);
      chk($sformatf("T5.upd@%0d", e), {7'd0, bus_b.o_upd}, {7'd0, (e == NFF + 2)});
      chk($sformatf("T5.bus@%0d", e), bus_b.o_bus, (e >= NFF + 2) ? 8'hA5 : 8'h00);
    end

    // T6: rise/fall pulses on F0 -> 3C
    repeat (12) step(8'hF0);
    chk("T6.pre", bus_a.o_bus, 8'hF0);
    for (int e = 1; e <= 9; e++) begin
      step(8'h3C);
`ifdef LIBHDL_SYNC_BUS_STABLE_EDGE_EN
      chk($sformatf("T6.rise@%0d", e), bus_a.o_rise, (e == 7) ? 8'h0C : 8'h00);
      chk($sformatf("T6.fall@%0d", e), bus_a.o_fall, (e == 7) ? 8'hC0 : 8'h00);
`else
      chk($sformatf("T6.rise@%0d", e), bus_a.o_rise, 8'h00);
      chk($sformatf("T6.fall@%0d", e), bus_a.o_fall, 8'h00);
`endif
    end

    // Random segments, including a reset landing mid-settle
    for (int k = 0; k < 60; k++) begin
      if (k == 30) begin
        step(8'h77);
        step(8'h77);
        step(8'h77);
        rst = 1'b1;
        step(8'h77);
        rst = 1'b0;
      end
      v = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 4)];
      repeat ($urandom_range(1, 7)) step(v);
    end
    repeat (12) step(8'hC3);
    chk("END.o_bus", bus_a.o_bus, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
